// File: rtl/ysyx_23060077_riscv_mem_arbiter_pkg.sv
// Shared encodings for the IFU/LSU memory-port arbiter.
package ysyx_23060077_riscv_mem_arbiter_pkg;

  localparam logic ARB_OWNER_IFU = 1'b0;
  localparam logic ARB_OWNER_LSU = 1'b1;

  localparam logic [1:0] ARB_ST_IDLE = 2'd0;
  localparam logic [1:0] ARB_ST_REQ  = 2'd1;
  localparam logic [1:0] ARB_ST_RESP = 2'd2;

  localparam int unsigned ARB_TIMEOUT = 255;

endpackage

// File: rtl/ysyx_23060077_riscv_rr_arb2.sv
// Two-way round-robin grant: bit 0 is the IFU, bit 1 is the LSU.
module ysyx_23060077_riscv_rr_arb2
  import ysyx_23060077_riscv_mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // Tie goes to whoever was not served last.
      2'b11:   grant = (last == ARB_OWNER_LSU) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/ysyx_23060077_riscv_mem_arbiter.sv
// Shares one memory port between the IFU and LSU: round-robin grant, one outstanding
// transaction, registered single-cycle responses and a response timeout.
module ysyx_23060077_riscv_mem_arbiter
  import ysyx_23060077_riscv_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = ARB_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_resp_data,
  output logic                ifu_resp_err,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_resp_data,
  output logic                lsu_resp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data,
  output logic                busy
);

  localparam int unsigned MaskW = DATA_W / 8;
  localparam int unsigned CntW  = $clog2(TIMEOUT + 1);

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MaskW-1:0]  wmask_q, wmask_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              early_q, early_d;
  logic [DATA_W-1:0] early_data_q, early_data_d;
  logic              ifu_rv_q, ifu_rv_d, ifu_re_q, ifu_re_d;
  logic              lsu_rv_q, lsu_rv_d, lsu_re_q, lsu_re_d;
  logic [DATA_W-1:0] ifu_rd_q, ifu_rd_d, lsu_rd_q, lsu_rd_d;

  logic              can_grant;
  logic [1:0]        req_masked;
  logic [1:0]        grant;
  logic              resp_fire, resp_err;
  logic [DATA_W-1:0] resp_data;

  // The IDLE cycle carrying a response pulse never grants; reset also forces ready low.
  assign can_grant  = (state_q == ARB_ST_IDLE) && !ifu_rv_q && !lsu_rv_q && !rst;
  assign req_masked = can_grant ? {lsu_req_valid, ifu_req_valid} : 2'b00;

  ysyx_23060077_riscv_rr_arb2 u_rr_arb2 (
    .req   (req_masked),
    .last  (last_q),
    .grant (grant)
  );

  assign ifu_req_ready  = grant[0];
  assign lsu_req_ready  = grant[1];
  assign mem_req_valid  = (state_q == ARB_ST_REQ);
  assign busy           = (state_q != ARB_ST_IDLE);
  assign mem_addr       = addr_q;
  assign mem_wen        = wen_q;
  assign mem_wdata      = wdata_q;
  assign mem_wmask      = wmask_q;
  assign ifu_resp_valid = ifu_rv_q;
  assign ifu_resp_data  = ifu_rd_q;
  assign ifu_resp_err   = ifu_re_q;
  assign lsu_resp_valid = lsu_rv_q;
  assign lsu_resp_data  = lsu_rd_q;
  assign lsu_resp_err   = lsu_re_q;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    cnt_d        = cnt_q;
    early_d      = early_q;
    early_data_d = early_data_q;
    resp_fire    = 1'b0;
    resp_err     = 1'b0;
    resp_data    = '0;

    unique case (state_q)
      ARB_ST_IDLE: begin
        if (|grant) begin
          owner_d = grant[1] ? ARB_OWNER_LSU : ARB_OWNER_IFU;
          last_d  = owner_d;
          addr_d  = grant[1] ? lsu_addr : ifu_addr;
          wen_d   = grant[1] & lsu_wen;
          wdata_d = grant[1] ? lsu_wdata : '0;
          wmask_d = grant[1] ? lsu_wmask : '0;
          state_d = ARB_ST_REQ;
        end
      end
      ARB_ST_REQ: begin
        if (mem_req_ready) begin
          state_d      = ARB_ST_RESP;
          cnt_d        = '0;
          // A response arriving with the handshake is held for the first RESP cycle.
          early_d      = mem_resp_valid;
          early_data_d = mem_resp_data;
        end
      end
      ARB_ST_RESP: begin
        if (early_q || mem_resp_valid) begin
          resp_fire = 1'b1;
          resp_data = early_q ? early_data_q : mem_resp_data;
          early_d   = 1'b0;
          state_d   = ARB_ST_IDLE;
        end else begin
          if (cnt_q != CntW'(TIMEOUT)) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (cnt_q == CntW'(TIMEOUT - 1)) begin
            resp_fire = 1'b1;
            resp_err  = 1'b1;
            state_d   = ARB_ST_IDLE;
          end
        end
      end
      default: state_d = ARB_ST_IDLE;
    endcase

    ifu_rv_d = resp_fire && (owner_q == ARB_OWNER_IFU);
    ifu_re_d = ifu_rv_d && resp_err;
    ifu_rd_d = ifu_rv_d ? resp_data : '0;
    lsu_rv_d = resp_fire && (owner_q == ARB_OWNER_LSU);
    lsu_re_d = lsu_rv_d && resp_err;
    lsu_rd_d = (lsu_rv_d && !wen_q) ? resp_data : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB_ST_IDLE;
      owner_q      <= ARB_OWNER_IFU;
      last_q       <= ARB_OWNER_LSU;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      cnt_q        <= '0;
      early_q      <= 1'b0;
      early_data_q <= '0;
      ifu_rv_q     <= 1'b0;
      ifu_re_q     <= 1'b0;
      ifu_rd_q     <= '0;
      lsu_rv_q     <= 1'b0;
      lsu_re_q     <= 1'b0;
      lsu_rd_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      cnt_q        <= cnt_d;
      early_q      <= early_d;
      early_data_q <= early_data_d;
      ifu_rv_q     <= ifu_rv_d;
      ifu_re_q     <= ifu_re_d;
      ifu_rd_q     <= ifu_rd_d;
      lsu_rv_q     <= lsu_rv_d;
      lsu_re_q     <= lsu_re_d;
      lsu_rd_q     <= lsu_rd_d;
    end
  end

endmodule
